// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: word memory for the RV32 CPU instruction/data ports with program load and halt register
module cpu_mem_responder #(
  parameter int ADDR_WIDTH = 14,
  parameter logic [31:0] HALT_ADDR = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_read,
  input  logic [31:0]           instr_addr,
  output logic [31:0]           instr_out,
  input  logic                  data_read,
  input  logic [3:0]            data_write,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic                  halted,
  output logic [31:0]           halt_code,
  output logic [31:0]           store_count
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_d;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] i_idx, d_idx;
  logic i_ok, d_ok, d_halt, wr_en, mem_wr, halt_wr, unused_ok;
  assign i_idx = instr_addr[ADDR_WIDTH+1:2];
  assign d_idx = data_addr[ADDR_WIDTH+1:2];
  assign i_ok = instr_addr[31:ADDR_WIDTH+2] == '0;
  assign d_ok = data_addr[31:ADDR_WIDTH+2] == '0;
  assign d_halt = data_addr[31:2] == HALT_ADDR[31:2];
  assign unused_ok = ^{instr_addr[1:0], data_addr[1:0]};
  // the load port pre-empts every data-port write, whatever its address
  assign wr_en = |data_write && !rst && !load_en && state == RUN;
  assign mem_wr = wr_en && d_ok;
  assign halt_wr = wr_en && d_halt && data_write == 4'hf;
  assign halted = state == HALT;
  always_comb state_d = halt_wr ? HALT : state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (mem_wr)
      for (int k = 0; k < 4; k++)
        if (data_write[k]) mem[d_idx][8*k +: 8] <= data_in[8*k +: 8];
  end
  // reads sample the array before this edge's write lands (read-first)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_out   <= '0;
      data_out    <= '0;
      halt_code   <= '0;
      store_count <= '0;
    end else begin
      if (instr_read) instr_out <= state == HALT ? 32'h0000_0013 : i_ok ? mem[i_idx] : '0;
      if (data_read) data_out <= d_halt ? halt_code : d_ok ? mem[d_idx] : '0;
      if (halt_wr) halt_code <= data_in;
      if ((mem_wr || halt_wr) && ~&store_count) store_count <= store_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: randomized scoreboard bench for cpu_mem_responder against a spec-level model
module tb_cpu_mem_responder;
  localparam logic [31:0] HALT_ADDR = 32'h0001_0000;
  localparam logic [31:0] MEM_BYTES = 32'h0001_0000;
  logic clk = 0, rst = 1;
  logic instr_read = 0, data_read = 0, load_en = 0;
  logic [31:0] instr_addr = 0, data_addr = 0, data_in = 0, load_data = 0;
  logic [3:0] data_write = 0;
  logic [13:0] load_addr = 0;
  logic [31:0] instr_out, data_out, halt_code, store_count;
  logic halted;

  always #5 clk = ~clk;

  cpu_mem_responder dut (
    .clk(clk), .rst(rst),
    .instr_read(instr_read), .instr_addr(instr_addr), .instr_out(instr_out),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_in(data_in), .data_out(data_out),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .halted(halted), .halt_code(halt_code), .store_count(store_count)
  );

  typedef struct {
    logic [31:0] instr, data, hc, cnt;
    logic h;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;

  logic [31:0] m_mem [int];
  logic [31:0] m_instr = 0, m_data = 0, m_hc = 0, m_cnt = 0;
  logic m_h = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a < MEM_BYTES && m_mem.exists(int'(a / 4))) return m_mem[int'(a / 4)];
    return 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic issue(input logic r, input logic ri, input logic [31:0] ia, input logic rd,
                       input logic [3:0] dw, input logic [31:0] da, input logic [31:0] di,
                       input logic le, input logic [13:0] la, input logic [31:0] ld);
    logic [31:0] mask;
    @(negedge clk);
    rst = r; instr_read = ri; instr_addr = ia; data_read = rd; data_write = dw;
    data_addr = da; data_in = di; load_en = le; load_addr = la; load_data = ld;
    if (r) begin
      m_instr = 0; m_data = 0; m_hc = 0; m_cnt = 0; m_h = 0;
    end else begin
      if (ri) m_instr = m_h ? 32'h0000_0013 : word(ia);
      if (rd) m_data = (da == HALT_ADDR) ? m_hc : word(da);
      if (!le && dw != 0 && !m_h) begin
        if (da < MEM_BYTES) begin
          mask = {{8{dw[3]}}, {8{dw[2]}}, {8{dw[1]}}, {8{dw[0]}}};
          m_mem[int'(da / 4)] = (word(da) & ~mask) | (di & mask);
          if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end else if (da == HALT_ADDR && dw == 4'hf) begin
          m_hc = di; m_h = 1;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
      end
    end
    if (le) m_mem[int'(la)] = ld;
    exp_q.push_back('{m_instr, m_data, m_hc, m_cnt, m_h});
  endtask

  task automatic rnd();
    logic [3:0] dw;
    logic [31:0] da, ia;
    int sel;
    dw = ($urandom % 2 != 0) ? 4'($urandom) : 4'h0;
    sel = int'($urandom % 20);
    da = sel == 0 ? 32'h0004_0004 : sel == 1 ? HALT_ADDR : $urandom % 64;
    if (da == HALT_ADDR && dw == 4'hf) dw = 4'h7;
    ia = ($urandom % 16 == 0) ? 32'h0004_0000 + $urandom % 64 : $urandom % 64;
    issue(0, 1'($urandom), ia, 1'($urandom), dw, da, $urandom,
          $urandom % 8 == 0, 14'($urandom % 16), $urandom);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("instr_out", instr_out, e.instr);
        chk("data_out", data_out, e.data);
        chk("halt_code", halt_code, e.hc);
        chk("store_count", store_count, e.cnt);
        chk("halted", {31'b0, halted}, {31'b0, e.h});
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) issue(1, 0, 0, 0, 0, 0, 0, 1, 14'(i), $urandom);
    for (int i = 0; i < 4; i++) issue(0, 1, 32'(i * 4), 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 1, 14'd8, 32'h1122_3344);
    issue(0, 0, 0, 0, 4'b0101, 32'h20, 32'hAABB_CCDD, 0, 0, 0);
    issue(0, 0, 0, 1, 0, 32'h20, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) rnd();
    issue(0, 0, 0, 0, 4'h3, HALT_ADDR, 32'hDEAD_BEEF, 0, 0, 0);
    issue(0, 0, 0, 0, 4'hf, 32'h0004_0000, 32'h1234_5678, 0, 0, 0);
    issue(0, 0, 0, 1, 0, 32'h0004_0000, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 4'hf, 32'h14, 32'h9, 1, 14'd5, 32'h5);
    issue(0, 0, 0, 1, 0, 32'h14, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 4'hf, HALT_ADDR, 32'h0000_002A, 0, 0, 0);
    issue(0, 0, 0, 0, 4'hf, 32'h0, 32'hFFFF_FFFF, 0, 0, 0);
    issue(0, 1, 32'h0, 1, 0, 32'h0, 0, 0, 0, 0);
    issue(0, 0, 0, 1, 0, HALT_ADDR, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) rnd();
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 32'h0, 1, 0, 32'h0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 4'hf, 32'h4, 32'hCAFE_F00D, 0, 0, 0);
    issue(0, 1, 32'h4, 1, 0, 32'h4, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) rnd();
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
